// File: rtl/mem_io_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_io_responder_pkg
// Shared constants for the CPU memory-bus responder: I/O page default,
// register offsets inside the I/O page, STATUS/CTRL bit positions and a
// helper that assembles the STATUS read byte.
// -----------------------------------------------------------------------------
package mem_io_responder_pkg;

    // High address byte that selects the I/O page by default
    localparam logic [7:0] IO_PAGE_DEFAULT = 8'hD0;

    // Register offsets within the I/O page (Address[7:0])
    localparam logic [7:0] TXDATA = 8'h00;
    localparam logic [7:0] STATUS = 8'h01;
    localparam logic [7:0] RELOAD = 8'h02;
    localparam logic [7:0] CTRL   = 8'h03;
    localparam logic [7:0] COUNT  = 8'h04;

    // STATUS bit indices
    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_TFLAG = 2;
    localparam int STAT_OVF   = 3;

    // CTRL bit indices
    localparam int CTRL_EN    = 0;
    localparam int CTRL_IRQEN = 1;

    // Assemble the STATUS read value; upper nibble always reads zero
    function automatic logic [7:0] pack_status(
        input logic empty,
        input logic full,
        input logic tflag,
        input logic ovf
    );
        logic [7:0] v;
        v             = 8'h00;
        v[STAT_EMPTY] = empty;
        v[STAT_FULL]  = full;
        v[STAT_TFLAG] = tflag;
        v[STAT_OVF]   = ovf;
        return v;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Synchronous first-word-fall-through byte FIFO. The head entry is always
// presented on o_dout; a pop advances it on the next edge. A push while full
// is accepted only when a pop happens in the same cycle.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset (clears contents)
//   i_push, i_din       push request and data
//   i_pop               pop request (ignored while empty)
//   o_dout              head byte
//   o_full, o_empty     occupancy flags
//   o_count             number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_din,
    input  logic                     i_pop,
    output logic [7:0]               o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign w_pop   = i_pop && (r_count != CW'(0));
    // Full FIFO still takes a push when the head leaves in the same cycle
    assign w_push  = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));
    assign o_count = r_count;

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
// Drop-in replacement for the memory instance beside the CPU. Decodes the CPU
// address into a RAM region (0 .. 2^RAM_AW-1), one I/O page and unmapped space.
// The I/O page holds a byte TX FIFO with a valid/ready stream output and an
// 8-bit reload timer with an interrupt flag.
// Ports:
//   CLK, R_N            clock, asynchronous active-low reset
//   Address, DataIn, WE CPU bus; writes commit on the rising edge
//   DataOut             combinational read data (0xFF when unmapped)
//   tx_valid, tx_data   FIFO head stream toward the serial transmitter
//   tx_ready            transmitter accepts the head
//   irq                 registered timer_flag & irq_en
// -----------------------------------------------------------------------------
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int         RAM_AW     = 11,
    parameter logic [7:0] IO_PAGE    = IO_PAGE_DEFAULT,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        R_N,
    input  logic [15:0] Address,
    input  logic [7:0]  DataIn,
    input  logic        WE,
    output logic [7:0]  DataOut,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    // RAM array: intentionally not reset so contents survive R_N
    logic [7:0] r_ram [2**RAM_AW];

    logic [7:0] r_reload;
    logic       r_en;
    logic       r_irq_en;
    logic [7:0] r_count;
    logic       r_tflag;
    logic       r_ovf;
    logic       r_irq;

    logic           w_ram_sel;
    logic           w_io_sel;
    logic [7:0]     w_off;
    logic           w_io_wr;
    logic           w_wr_txdata;
    logic           w_wr_status;
    logic           w_wr_reload;
    logic           w_wr_ctrl;
    logic           w_en_rise;
    logic           w_timer_fire;
    logic           w_push;
    logic           w_pop;
    logic           w_ovf_event;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [FCW-1:0] w_fifo_count;

    // Address decode; RAM wins should the I/O page ever overlap it
    assign w_ram_sel   = ((Address >> RAM_AW) == 16'd0);
    assign w_io_sel    = !w_ram_sel && (Address[15:8] == IO_PAGE);
    assign w_off       = Address[7:0];

    assign w_io_wr     = WE && w_io_sel;
    assign w_wr_txdata = w_io_wr && (w_off == TXDATA);
    assign w_wr_status = w_io_wr && (w_off == STATUS);
    assign w_wr_reload = w_io_wr && (w_off == RELOAD);
    assign w_wr_ctrl   = w_io_wr && (w_off == CTRL);
    assign w_en_rise   = w_wr_ctrl && DataIn[CTRL_EN] && !r_en;

    assign w_timer_fire = r_en && (r_count == 8'h00);

    assign w_push      = w_wr_txdata;
    assign w_pop       = tx_valid && tx_ready;
    // Dropped push: full and nothing leaving this cycle
    assign w_ovf_event = w_push && (w_fifo_count == FCW'(FIFO_DEPTH)) && !w_pop;

    assign tx_valid    = !w_fifo_empty;
    assign irq         = r_irq;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (R_N),
        .i_push  (w_push),
        .i_din   (DataIn),
        .i_pop   (w_pop),
        .o_dout  (tx_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // RAM synchronous write port
    always_ff @(posedge CLK) begin
        if (WE && w_ram_sel) begin
            r_ram[Address[RAM_AW-1:0]] <= DataIn;
        end
    end

    // RELOAD/CTRL registers and the timer counter; CPU writes beat the auto-reload
    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            r_reload <= 8'hFF;
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_count  <= 8'hFF;
        end else begin
            if (w_wr_reload) begin
                r_reload <= DataIn;
            end
            if (w_wr_ctrl) begin
                r_en     <= DataIn[CTRL_EN];
                r_irq_en <= DataIn[CTRL_IRQEN];
            end
            if (w_wr_reload) begin
                r_count <= DataIn;
            end else if (w_en_rise) begin
                r_count <= r_reload;
            end else if (w_timer_fire) begin
                r_count <= r_reload;
            end else if (r_en) begin
                r_count <= r_count - 8'd1;
            end
        end
    end

    // Sticky flags; a same-cycle set wins over a STATUS write-clear
    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            r_tflag <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_timer_fire) begin
                r_tflag <= 1'b1;
            end else if (w_wr_status && DataIn[STAT_TFLAG]) begin
                r_tflag <= 1'b0;
            end
            if (w_ovf_event) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && DataIn[STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Interrupt output, one cycle behind flag/enable
    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_tflag && r_irq_en;
        end
    end

    // Combinational read mux: RAM, I/O registers, else 0xFF
    always_comb begin
        DataOut = 8'hFF;
        if (w_ram_sel) begin
            DataOut = r_ram[Address[RAM_AW-1:0]];
        end else if (w_io_sel) begin
            case (w_off)
                TXDATA:  DataOut = 8'h00;
                STATUS:  DataOut = pack_status(w_fifo_empty, w_fifo_full, r_tflag, r_ovf);
                RELOAD:  DataOut = r_reload;
                CTRL:    DataOut = {6'b000000, r_irq_en, r_en};
                COUNT:   DataOut = r_count;
                default: DataOut = 8'h00;
            endcase
        end else begin
            DataOut = 8'hFF;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_io_responder
// Directed scenarios plus randomized traffic, compared against a behavioural
// model (RAM array, byte queue, timer/flag rules) kept in this module.
// -----------------------------------------------------------------------------
module tb_mem_io_responder;

    localparam int DEPTH = 8;

    logic        CLK      = 1'b0;
    logic        R_N      = 1'b0;
    logic [15:0] Address  = 16'h0000;
    logic [7:0]  DataIn   = 8'h00;
    logic        WE       = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  DataOut;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_ram [2048];
    bit         m_vld [2048];
    logic [7:0] m_q [$];
    bit         m_ovf, m_flag, m_en, m_ie, m_irq;
    logic [7:0] m_reload, m_cnt;

    mem_io_responder #(
        .RAM_AW     (11),
        .IO_PAGE    (8'hD0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK      (CLK),
        .R_N      (R_N),
        .Address  (Address),
        .DataIn   (DataIn),
        .WE       (WE),
        .DataOut  (DataOut),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_flag   = 1'b0;
        m_en     = 1'b0;
        m_ie     = 1'b0;
        m_irq    = 1'b0;
        m_reload = 8'hFF;
        m_cnt    = 8'hFF;
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a, output bit known);
        known = 1'b1;
        if (a < 16'd2048) begin
            known = m_vld[a[10:0]];
            return m_ram[a[10:0]];
        end
        if (a[15:8] == 8'hD0) begin
            case (a[7:0])
                8'h01:   return {4'h0, m_ovf, m_flag, (m_q.size() == DEPTH), (m_q.size() == 0)};
                8'h02:   return m_reload;
                8'h03:   return {6'h00, m_ie, m_en};
                8'h04:   return m_cnt;
                default: return 8'h00;
            endcase
        end
        return 8'hFF;
    endfunction

    // Apply one clock edge of behaviour from the pre-edge state
    task automatic model_edge(input logic [15:0] a, input logic [7:0] d, input bit w, input bit r);
        bit         io_w, pop, push, ovf_ev, fire, old_en;
        logic [7:0] old_reload, old_cnt;
        io_w       = w && (a[15:8] == 8'hD0);
        pop        = r && (m_q.size() > 0);
        push       = io_w && (a[7:0] == 8'h00);
        ovf_ev     = push && (m_q.size() == DEPTH) && !pop;
        fire       = m_en && (m_cnt == 8'h00);
        old_en     = m_en;
        old_reload = m_reload;
        old_cnt    = m_cnt;
        m_irq      = m_flag && m_ie;
        if (io_w && a[7:0] == 8'h02) begin
            m_reload = d;
            m_cnt    = d;
        end else if (io_w && a[7:0] == 8'h03 && d[0] && !old_en) begin
            m_cnt = old_reload;
        end else if (old_en) begin
            m_cnt = (old_cnt == 8'h00) ? old_reload : old_cnt - 8'd1;
        end
        if (io_w && a[7:0] == 8'h03) begin
            m_en = d[0];
            m_ie = d[1];
        end
        if (fire) m_flag = 1'b1;
        else if (io_w && a[7:0] == 8'h01 && d[2]) m_flag = 1'b0;
        if (ovf_ev) m_ovf = 1'b1;
        else if (io_w && a[7:0] == 8'h01 && d[3]) m_ovf = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (push && !ovf_ev) m_q.push_back(d);
        if (w && a < 16'd2048) begin
            m_ram[a[10:0]] = d;
            m_vld[a[10:0]] = 1'b1;
        end
    endtask

    // One bus cycle: drive, compare all outputs against the model, clock it
    task automatic step(input logic [15:0] a, input logic [7:0] d, input bit w, input bit r);
        bit         known;
        logic [7:0] exp;
        Address  = a;
        DataIn   = d;
        WE       = w;
        tx_ready = r;
        #1;
        exp = model_read(a, known);
        if (known) check_eq("dataout", DataOut, exp);
        check_eq("tx_valid", {7'h00, tx_valid}, {7'h00, (m_q.size() > 0)});
        if (m_q.size() > 0) check_eq("tx_data", tx_data, m_q[0]);
        check_eq("irq", {7'h00, irq}, {7'h00, m_irq});
        @(posedge CLK);
        model_edge(a, d, w, r);
        #1;
    endtask

    // Read-only look at an address within the current cycle
    task automatic peek(input logic [15:0] a, input logic [7:0] exp, input string tag);
        Address = a;
        WE      = 1'b0;
        #1;
        check_eq(tag, DataOut, exp);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        bit          w, r;
        int          sel;

        for (int i = 0; i < 2048; i++) m_vld[i] = 1'b0;
        model_reset();
        #3;
        check_eq("rst_tx_valid", {7'h00, tx_valid}, 8'h00);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_irq", {7'h00, irq}, 8'h00);
        #19;
        R_N = 1'b1;

        // Reset-state reads
        peek(16'hD001, 8'h01, "rst_status");
        peek(16'hD002, 8'hFF, "rst_reload");
        peek(16'hD003, 8'h00, "rst_ctrl");
        peek(16'hD004, 8'hFF, "rst_count");

        // RAM and unmapped space
        step(16'h0000, 8'hC3, 1'b1, 1'b0);
        step(16'h07FF, 8'h3C, 1'b1, 1'b0);
        step(16'h0123, 8'h5A, 1'b1, 1'b0);
        peek(16'h0123, 8'h5A, "ram_rd");
        peek(16'hE000, 8'hFF, "unmapped_rd");
        peek(16'h0800, 8'hFF, "ram_end_rd");
        step(16'hE000, 8'h11, 1'b1, 1'b0);
        step(16'h0800, 8'h22, 1'b1, 1'b0);
        peek(16'h0000, 8'hC3, "ram_alias0");
        peek(16'h0123, 8'h5A, "ram_keep");
        peek(16'h07FF, 8'h3C, "ram_top");

        // Fill FIFO, then overflow
        for (int i = 1; i <= 8; i++) step(16'hD000, 8'(i), 1'b1, 1'b0);
        peek(16'hD001, 8'h02, "status_full");
        step(16'hD000, 8'h09, 1'b1, 1'b0);
        peek(16'hD001, 8'h0A, "status_ovf");
        for (int i = 1; i <= 8; i++) begin
            check_eq("drain_seq", tx_data, 8'(i));
            step(16'hD004, 8'h00, 1'b0, 1'b1);
        end
        check_eq("drained", {7'h00, tx_valid}, 8'h00);
        step(16'hD001, 8'h08, 1'b1, 1'b0);
        peek(16'hD001, 8'h01, "ovf_clr");

        // Push into a full FIFO with simultaneous pop
        for (int i = 1; i <= 8; i++) step(16'hD000, 8'(i), 1'b1, 1'b0);
        step(16'hD000, 8'h77, 1'b1, 1'b1);
        peek(16'hD001, 8'h02, "full_pushpop");
        for (int i = 0; i < 8; i++) begin
            check_eq("pp_seq", tx_data, (i < 7) ? 8'(i + 2) : 8'h77);
            step(16'hD004, 8'h00, 1'b0, 1'b1);
        end

        // Timer: reload 3, enable with irq
        step(16'hD002, 8'h03, 1'b1, 1'b0);
        step(16'hD003, 8'h03, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(16'hD004, 8'h00, 1'b0, 1'b0);
        peek(16'hD001, 8'h05, "tflag_set");
        check_eq("irq_lag", {7'h00, irq}, 8'h00);
        step(16'hD004, 8'h00, 1'b0, 1'b0);
        check_eq("irq_set", {7'h00, irq}, 8'h01);
        step(16'hD001, 8'h04, 1'b1, 1'b0);
        check_eq("irq_hold", {7'h00, irq}, 8'h01);
        step(16'hD004, 8'h00, 1'b0, 1'b0);
        check_eq("irq_drop", {7'h00, irq}, 8'h00);
        for (int i = 0; i < 12; i++) step(16'hD001, 8'h00, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            d   = 8'($urandom_range(0, 255));
            w   = ($urandom_range(0, 1) == 1);
            if (sel <= 2) begin
                a = (sel == 0) ? 16'h07FF : 16'($urandom_range(0, 31));
            end else if (sel <= 7) begin
                a = {8'hD0, 8'($urandom_range(0, 6))};
                if (a[7:0] == 8'h02) d = 8'($urandom_range(0, 6));
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 16'h0800;
                    1:       a = 16'hE000;
                    2:       a = 16'hD100;
                    default: a = 16'hFFFF;
                endcase
            end
            r = ($urandom_range(0, 3) < ((((i / 50) % 2) == 1) ? 1 : 3));
            step(a, d, w, r);
        end

        // Mid-stream reset with FIFO holding 3 bytes and timer running
        step(16'hD003, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(16'hD004, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(16'hD000, 8'(8'hA0 + i), 1'b1, 1'b0);
        step(16'hD002, 8'h05, 1'b1, 1'b0);
        step(16'hD003, 8'h03, 1'b1, 1'b0);
        step(16'hD004, 8'h00, 1'b0, 1'b0);
        check_eq("pre_rst_valid", {7'h00, tx_valid}, 8'h01);
        R_N = 1'b0;
        #1;
        check_eq("mid_rst_valid", {7'h00, tx_valid}, 8'h00);
        check_eq("mid_rst_irq", {7'h00, irq}, 8'h00);
        model_reset();
        #20;
        R_N = 1'b1;
        peek(16'hD001, 8'h01, "post_rst_status");
        peek(16'hD004, 8'hFF, "post_rst_count");
        peek(16'h0123, 8'h5A, "post_rst_ram");
        for (int i = 0; i < 5; i++) step(16'hD004, 8'h00, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
